// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse packet decoder: FSM encoding, byte0 bit
// positions, default command/ACK bytes and the saturation values for overflowed axes.
package mouse_pkg;

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_WAIT_TX  = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_PKT1     = 3'd3;
  localparam logic [2:0] ST_PKT2     = 3'd4;
  localparam logic [2:0] ST_PKT3     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam int B0_BTN_L = 0;
  localparam int B0_BTN_R = 1;
  localparam int B0_BTN_M = 2;
  localparam int B0_SYNC  = 3;
  localparam int B0_X_SGN = 4;
  localparam int B0_Y_SGN = 5;
  localparam int B0_X_OVF = 6;
  localparam int B0_Y_OVF = 7;

  localparam logic [7:0] DEF_INIT_CMD = 8'hF4;
  localparam logic [7:0] DEF_ACK_BYTE = 8'hFA;

  localparam logic [8:0] SAT_POS = 9'h0FF;
  localparam logic [8:0] SAT_NEG = 9'h100;

  // An overflowed axis clamps to the extreme of its sign instead of wrapping.
  function automatic logic [8:0] axis_delta(input logic sgn, input logic ovf,
                                            input logic [7:0] mag);
    if (ovf) return sgn ? SAT_NEG : SAT_POS;
    return {sgn, mag};
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Cycle counter for the ACK-wait and inter-byte timeouts; expired is asserted
// while enabled and the count sits at TIMEOUT_CYCLES-1.
module ps2_timeout_counter #(
  parameter int TO_W           = 22,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TERM)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == TERM);

endmodule

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse front end: enables streaming (0xF4/ACK), assembles 3-byte packets and
// emits signed deltas plus buttons. Define MOUSE_PKT_SYNC_EN to drop byte0 candidates with bit3 clear.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter logic [7:0] INIT_CMD       = DEF_INIT_CMD,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter int         TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       btnl,
  output logic       btnr,
  output logic       btnm,
  output logic       m_done_tick,
  output logic       init_done,
  output logic [2:0] dbg_state
);

  logic [2:0] state_q, state_d;
  logic       init_done_q, init_done_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [8:0] xm_q, xm_d;
  logic [8:0] ym_q, ym_d;
  logic [2:0] btn_q, btn_d;
  logic       byte0_ok;
  logic       to_clear;
  logic       to_enable;
  logic       to_expired;

`ifdef MOUSE_PKT_SYNC_EN
  assign byte0_ok = rx_data[B0_SYNC];
`else
  assign byte0_ok = 1'b1;
`endif

  // Timeouts only apply while a response or the rest of a packet is owed;
  // idle time between packets is unbounded.
  assign to_enable = (state_q == ST_WAIT_ACK) || (state_q == ST_PKT2) ||
                     (state_q == ST_PKT3);
  assign to_clear  = (state_d != state_q);

  ps2_timeout_counter #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  // A byte arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    xm_d        = xm_q;
    ym_d        = ym_q;
    btn_d       = btn_q;
    case (state_q)
      ST_INIT:     state_d = ST_WAIT_TX;
      ST_WAIT_TX:  if (tx_done_tick) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (rx_done_tick && (rx_data == ACK_BYTE)) begin
          state_d     = ST_PKT1;
          init_done_d = 1'b1;
        end else if (to_expired) begin
          state_d = ST_INIT;
        end
      end
      ST_PKT1: begin
        if (rx_done_tick && byte0_ok) begin
          b0_d    = rx_data;
          state_d = ST_PKT2;
        end
      end
      ST_PKT2: begin
        if (rx_done_tick) begin
          b1_d    = rx_data;
          state_d = ST_PKT3;
        end else if (to_expired) begin
          state_d = ST_PKT1;
        end
      end
      ST_PKT3: begin
        if (rx_done_tick) begin
          xm_d    = axis_delta(b0_q[B0_X_SGN], b0_q[B0_X_OVF], b1_q);
          ym_d    = axis_delta(b0_q[B0_Y_SGN], b0_q[B0_Y_OVF], rx_data);
          btn_d   = {b0_q[B0_BTN_M], b0_q[B0_BTN_R], b0_q[B0_BTN_L]};
          state_d = ST_DONE;
        end else if (to_expired) begin
          state_d = ST_PKT1;
        end
      end
      ST_DONE:     state_d = ST_PKT1;
      default:     state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_done_q <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      btn_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      xm_q        <= xm_d;
      ym_q        <= ym_d;
      btn_q       <= btn_d;
    end
  end

  // Outputs were loaded on the byte2 edge, so DONE is exactly the cycle they first show.
  assign wr_ps2      = (state_q == ST_INIT) && !reset;
  assign tx_data     = INIT_CMD;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnl        = btn_q[0];
  assign btnr        = btn_q[1];
  assign btnm        = btn_q[2];
  assign m_done_tick = (state_q == ST_DONE);
  assign init_done   = init_done_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/mouse_packet_decoder.md
Name: mouse_packet_decoder

Overview:
Upstream stage of the mouse position controller.
- Enables PS/2 streaming: sends 0xF4, waits for ACK 0xFA.
- Assembles the 3-byte PS/2 movement packets from the PS/2 byte receiver.
- Emits signed 9-bit X/Y deltas and button states, with a one-cycle done tick per packet.
- Sits between the PS/2 rx/tx byte layer and the cursor accumulator.

Parameters:
- INIT_CMD, 8'hF4, command byte sent after reset to enable data reporting.
- ACK_BYTE, 8'hFA, expected device acknowledge.
- TIMEOUT_CYCLES, 2_500_000, ACK-wait and inter-byte timeout (50 ms @ 50 MHz).
- TO_W, 22, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received PS/2 byte
- rx_done_tick  in  1  one-cycle strobe, rx_data valid
- tx_done_tick  in  1  one-cycle strobe, command byte fully sent
- wr_ps2  out  1  one-cycle request to transmit tx_data
- tx_data  out  8  byte to transmit
- xm  out  9  signed X delta, two's complement
- ym  out  9  signed Y delta, two's complement
- btnl  out  1  left button
- btnr  out  1  right button
- btnm  out  1  middle button
- m_done_tick  out  1  one-cycle strobe, new packet on xm/ym/btn*
- init_done  out  1  high once ACK received

Behaviour:
- Reset values:
  - All outputs 0.
  - tx_data = INIT_CMD.
  - FSM = INIT; timeout counter = 0.
- FSM states:
  - INIT: drive wr_ps2=1 for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: wait for tx_done_tick, then go to WAIT_ACK and clear the counter. rx bytes in this state are ignored.
  - WAIT_ACK:
    - rx_done_tick with rx_data==ACK_BYTE: go to PKT1, set init_done=1.
    - rx_done_tick with any other byte: stay in WAIT_ACK.
    - Counter reaches TIMEOUT_CYCLES-1: go to INIT (retry indefinitely).
  - PKT1: on rx_done_tick latch byte0, go to PKT2, clear counter.
  - PKT2: on rx_done_tick latch byte1, go to PKT3, clear counter.
  - PKT3: on rx_done_tick latch byte2, go to DONE.
  - PKT2/PKT3 timeout: counter reaches TIMEOUT_CYCLES-1 with no byte → discard partial packet, go to PKT1, outputs unchanged.
  - DONE: update outputs, pulse m_done_tick for one cycle, go to PKT1.
- Output mapping from byte0:
  - b0[0]=L, b0[1]=R, b0[2]=M.
  - b0[4]=X sign, b0[5]=Y sign.
  - b0[6]=X overflow, b0[7]=Y overflow.
- Delta construction:
  - xm = {b0[4], byte1}; ym = {b0[5], byte2}.
  - If the axis overflow bit is set, saturate: sign=1 → 9'h100 (−256), sign=0 → 9'h0FF (+255).
- Latency and hold:
  - xm/ym/btn* and m_done_tick update exactly 1 cycle after the byte2 rx_done_tick.
  - Values hold until the next completed packet.
- Counter rules:
  - Counts only in WAIT_ACK, PKT2, PKT3; clears on every state change.
  - Does not count in PKT1 (idle between packets is unbounded).
- Simultaneous rx_done_tick and timeout: the byte wins (accepted, no timeout).
- reset mid-operation: the FSM returns to INIT on the next edge, and init_done and the outputs clear.
- init_done stays 1 until reset.

Optional Feature:
MOUSE_PKT_SYNC_EN
- Defined: in PKT1, a byte with b0[3]==0 is dropped (FSM stays in PKT1), giving resync after a lost byte.
- Undefined: any byte in PKT1 is accepted as byte0.

Decomposition:
- Package mouse_pkg holds:
  - State encoding (INIT, WAIT_TX, WAIT_ACK, PKT1, PKT2, PKT3, DONE).
  - Byte0 bit-position constants.
  - Default INIT_CMD/ACK_BYTE values.
  - Saturation constants 9'h0FF and 9'h100.
- One sub-module, ps2_timeout_counter:
  - Inputs: clear, enable.
  - Output: expired.
  - Width TO_W, terminal value TIMEOUT_CYCLES-1.

Test Plan:
- Reset release → wr_ps2 single pulse, tx_data=0xF4; tx_done_tick then rx 0xFA → init_done=1.
- After init, bytes 0x09, 0x05, 0x03 → m_done_tick once; xm=+5, ym=+3, btnl=1, btnr=0, btnm=0.
- Bytes 0x38, 0xFB, 0x10 → xm=9'h1FB (−5), ym=9'h110 (−240), all buttons 0.
- Byte0 0x58 (X overflow, X sign) with bytes 0x00, 0x00 → xm=9'h100, ym=0.
- Byte 0x08 then silence for TIMEOUT_CYCLES (TIMEOUT_CYCLES=100 in sim) → no m_done_tick; next 0x08, 0x01, 0x01 → xm=1, ym=1.
- WAIT_ACK receives 0xFE then times out → a second wr_ps2 pulse. Separately, with MOUSE_PKT_SYNC_EN, byte 0x00 in PKT1 is ignored and the following 0x08, 0x02, 0x02 yields xm=2, ym=2.
